// File: rtl/mannix_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module : mannix_disp_pkg
// Brief  : Shared job descriptor layout and engine ids for the job dispatcher.
// Rev    : 1.0
// ============================================================================
package mannix_disp_pkg;

  localparam int DISP_NUM_ENG = 3;
  localparam int DISP_ENG_W   = 2;
  localparam int DISP_TAG_W   = 8;
  localparam int DISP_ADDR_W  = 19;

  localparam int ENG_FCC  = 0;
  localparam int ENG_POOL = 1;
  localparam int ENG_CNN  = 2;

  // Descriptor layout for the default cluster configuration.
  typedef struct packed {
    logic [DISP_ENG_W-1:0]  eng;
    logic                   barrier;
    logic [DISP_TAG_W-1:0]  tag;
    logic [DISP_ADDR_W-1:0] addr_x;
    logic [DISP_ADDR_W-1:0] addr_y;
    logic [DISP_ADDR_W-1:0] addr_z;
  } job_t;

  function automatic int eng_id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mannix_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : mannix_sync_fifo
// Brief  : Synchronous power-of-two FIFO with occupancy level, no bypass.
// Rev    : 1.0
// ============================================================================
module mannix_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int LVL_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [LVL_W-1:0]      level_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/mannix_job_dispatcher.sv
`default_nettype none
// ============================================================================
// Module : mannix_job_dispatcher
// Brief  : In-order job queue launching onto NUM_ENGINES engines with barrier
//          support and a serialised tagged completion stream.
// Rev    : 1.0
// ============================================================================
module mannix_job_dispatcher
  import mannix_disp_pkg::*;
#(
  parameter int NUM_ENGINES = DISP_NUM_ENG,
  parameter int QUEUE_DEPTH = 8,
  parameter int ADDR_WIDTH  = DISP_ADDR_W,
  parameter int TAG_WIDTH   = DISP_TAG_W,
  parameter int ENG_W       = eng_id_width(NUM_ENGINES),
  localparam int LVL_W      = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sw_job_valid_i,
  output logic                              sw_job_ready_o,
  input  logic [ENG_W-1:0]                  sw_job_eng_i,
  input  logic                              sw_job_barrier_i,
  input  logic [TAG_WIDTH-1:0]              sw_job_tag_i,
  input  logic [ADDR_WIDTH-1:0]             sw_job_addr_x_i,
  input  logic [ADDR_WIDTH-1:0]             sw_job_addr_y_i,
  input  logic [ADDR_WIDTH-1:0]             sw_job_addr_z_i,
  output logic [NUM_ENGINES-1:0]            eng_go_o,
  output logic [NUM_ENGINES*ADDR_WIDTH-1:0] eng_addr_x_o,
  output logic [NUM_ENGINES*ADDR_WIDTH-1:0] eng_addr_y_o,
  output logic [NUM_ENGINES*ADDR_WIDTH-1:0] eng_addr_z_o,
  input  logic [NUM_ENGINES-1:0]            eng_done_i,
  output logic [NUM_ENGINES-1:0]            eng_busy_ind_o,
  output logic                              job_done_o,
  output logic [TAG_WIDTH-1:0]              job_done_tag_o,
  output logic [ENG_W-1:0]                  job_done_eng_o,
  output logic [LVL_W-1:0]                  queue_level_o,
  output logic                              all_idle_o,
  output logic                              err_bad_eng_o,
  output logic                              err_spurious_done_o
);

  typedef struct packed {
    logic [ENG_W-1:0]      eng;
    logic                  barrier;
    logic [TAG_WIDTH-1:0]  tag;
    logic [ADDR_WIDTH-1:0] addr_x;
    logic [ADDR_WIDTH-1:0] addr_y;
    logic [ADDR_WIDTH-1:0] addr_z;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  entry_t                push_entry, head;
  logic                  fifo_full, fifo_empty;
  logic [LVL_W-1:0]      fifo_level, level_next;
  logic                  push_acc, pop, launch, head_bad;
  logic [NUM_ENGINES-1:0] head_sel, active;

  logic [NUM_ENGINES-1:0] busy_q, busy_d;
  logic [NUM_ENGINES-1:0] pend_q, pend_d;
  logic [NUM_ENGINES-1:0] go_q, go_d;
  logic [NUM_ENGINES-1:0] done_ok, done_bad;
  logic                   done_q;
  logic [TAG_WIDTH-1:0]   done_tag_q, done_tag_d;
  logic [ENG_W-1:0]       done_eng_q, done_eng_d;
  logic                   err_bad_q, err_spur_q;
  logic                   all_idle_q, all_idle_d;

  logic                   cpl_valid;
  logic [ENG_W-1:0]       cpl_idx;
  logic [TAG_WIDTH-1:0]   cpl_tag;
  logic [NUM_ENGINES-1:0] cpl_clr;

  logic [TAG_WIDTH-1:0]   tag_q    [NUM_ENGINES];
  logic [ADDR_WIDTH-1:0]  addr_x_q [NUM_ENGINES];
  logic [ADDR_WIDTH-1:0]  addr_y_q [NUM_ENGINES];
  logic [ADDR_WIDTH-1:0]  addr_z_q [NUM_ENGINES];

  assign push_entry = '{eng:     sw_job_eng_i,
                        barrier: sw_job_barrier_i,
                        tag:     sw_job_tag_i,
                        addr_x:  sw_job_addr_x_i,
                        addr_y:  sw_job_addr_y_i,
                        addr_z:  sw_job_addr_z_i};

  assign push_acc = sw_job_valid_i & ~fifo_full;

  mannix_sync_fifo #(
    .DATA_WIDTH (ENTRY_W),
    .DEPTH      (QUEUE_DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_acc),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // An all-zero select means the head names an engine that does not exist.
  always_comb begin
    head_sel = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      head_sel[i] = (head.eng == ENG_W'(i));
    end
  end

  assign active   = busy_q | pend_q;
  assign head_bad = ~fifo_empty & ~(|head_sel);
  assign launch   = ~fifo_empty & (|head_sel) & ~(|(head_sel & active))
                  & (~head.barrier | ~(|active));
  assign pop      = head_bad | launch;

  // Lowest pending engine wins; the descending loop leaves it as the final pick.
  always_comb begin
    cpl_valid = 1'b0;
    cpl_idx   = '0;
    cpl_tag   = '0;
    cpl_clr   = '0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        cpl_valid  = 1'b1;
        cpl_idx    = ENG_W'(i);
        cpl_tag    = tag_q[i];
        cpl_clr    = '0;
        cpl_clr[i] = 1'b1;
      end
    end
  end

  always_comb begin
    done_ok    = eng_done_i & busy_q;
    done_bad   = eng_done_i & ~busy_q;
    go_d       = launch ? head_sel : '0;
    busy_d     = (busy_q & ~done_ok) | go_d;
    pend_d     = (pend_q & ~cpl_clr) | done_ok;
    done_tag_d = cpl_valid ? cpl_tag : done_tag_q;
    done_eng_d = cpl_valid ? cpl_idx : done_eng_q;
    level_next = fifo_level + LVL_W'(push_acc) - LVL_W'(pop);
    all_idle_d = (level_next == '0) & ~(|busy_d) & ~(|pend_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      pend_q     <= '0;
      go_q       <= '0;
      done_q     <= 1'b0;
      done_tag_q <= '0;
      done_eng_q <= '0;
      err_bad_q  <= 1'b0;
      err_spur_q <= 1'b0;
      all_idle_q <= 1'b1;
    end else begin
      busy_q     <= busy_d;
      pend_q     <= pend_d;
      go_q       <= go_d;
      done_q     <= cpl_valid;
      done_tag_q <= done_tag_d;
      done_eng_q <= done_eng_d;
      err_bad_q  <= err_bad_q | head_bad;
      err_spur_q <= err_spur_q | (|done_bad);
      all_idle_q <= all_idle_d;
    end
  end

  // Launch is gated on pend, so a tag is never overwritten before it is reported.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
        tag_q[i]    <= '0;
        addr_x_q[i] <= '0;
        addr_y_q[i] <= '0;
        addr_z_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
        if (go_d[i]) begin
          tag_q[i]    <= head.tag;
          addr_x_q[i] <= head.addr_x;
          addr_y_q[i] <= head.addr_y;
          addr_z_q[i] <= head.addr_z;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_eng_out
    assign eng_addr_x_o[g*ADDR_WIDTH +: ADDR_WIDTH] = addr_x_q[g];
    assign eng_addr_y_o[g*ADDR_WIDTH +: ADDR_WIDTH] = addr_y_q[g];
    assign eng_addr_z_o[g*ADDR_WIDTH +: ADDR_WIDTH] = addr_z_q[g];
  end

  assign sw_job_ready_o      = ~fifo_full;
  assign eng_go_o            = go_q;
  assign eng_busy_ind_o      = busy_q;
  assign job_done_o          = done_q;
  assign job_done_tag_o      = done_tag_q;
  assign job_done_eng_o      = done_eng_q;
  assign queue_level_o       = fifo_level;
  assign all_idle_o          = all_idle_q;
  assign err_bad_eng_o       = err_bad_q;
  assign err_spurious_done_o = err_spur_q;

endmodule
`default_nettype wire

// File: tb/tb_mannix_job_dispatcher.sv
`default_nettype none
// ============================================================================
// Module : tb_mannix_job_dispatcher
// Brief  : Directed and randomized checks of the job dispatcher against a
//          queue-based reference model.
// Rev    : 1.0
// ============================================================================
module tb_mannix_job_dispatcher;
  import mannix_disp_pkg::*;

  localparam int NE = 3;
  localparam int QD = 8;
  localparam int AW = DISP_ADDR_W;
  localparam int TW = DISP_TAG_W;
  localparam int EW = DISP_ENG_W;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [EW-1:0] in_eng   = '0;
  logic          in_bar   = 1'b0;
  logic [TW-1:0] in_tag   = '0;
  logic [AW-1:0] in_ax = '0, in_ay = '0, in_az = '0;
  logic [NE-1:0] in_done  = '0;

  logic          ready, jd, idle, ebad, espur;
  logic [NE-1:0] go, busy;
  logic [NE*AW-1:0] oax, oay, oaz;
  logic [TW-1:0] jtag;
  logic [EW-1:0] jeng;
  logic [LW-1:0] level;

  int n_cmp = 0;
  int n_bad = 0;

  mannix_job_dispatcher #(
    .NUM_ENGINES (NE),
    .QUEUE_DEPTH (QD),
    .ADDR_WIDTH  (AW),
    .TAG_WIDTH   (TW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .sw_job_valid_i      (in_valid),
    .sw_job_ready_o      (ready),
    .sw_job_eng_i        (in_eng),
    .sw_job_barrier_i    (in_bar),
    .sw_job_tag_i        (in_tag),
    .sw_job_addr_x_i     (in_ax),
    .sw_job_addr_y_i     (in_ay),
    .sw_job_addr_z_i     (in_az),
    .eng_go_o            (go),
    .eng_addr_x_o        (oax),
    .eng_addr_y_o        (oay),
    .eng_addr_z_o        (oaz),
    .eng_done_i          (in_done),
    .eng_busy_ind_o      (busy),
    .job_done_o          (jd),
    .job_done_tag_o      (jtag),
    .job_done_eng_o      (jeng),
    .queue_level_o       (level),
    .all_idle_o          (idle),
    .err_bad_eng_o       (ebad),
    .err_spurious_done_o (espur)
  );

  always #5 clk = ~clk;

  // Reference model: job list, per-engine busy/pending flags and launch records.
  job_t             mq[$];
  bit   [NE-1:0]    m_busy, m_pend;
  logic [TW-1:0]    m_tag [NE];
  logic [NE*AW-1:0] m_ax, m_ay, m_az;
  logic [NE-1:0]    e_go;
  bit               e_done, e_bad, e_spur, e_idle;
  logic [TW-1:0]    e_dtag;
  logic [EW-1:0]    e_deng;

  function automatic void model_edge();
    bit [NE-1:0] busy0, pend0;
    bit          acc;
    job_t        h, nj;
    int          e;
    if (rst) begin
      mq.delete();
      m_busy = '0; m_pend = '0; e_go = '0;
      m_ax = '0; m_ay = '0; m_az = '0;
      e_done = 0; e_dtag = '0; e_deng = '0;
      e_bad = 0; e_spur = 0; e_idle = 1;
      return;
    end
    busy0  = m_busy;
    pend0  = m_pend;
    acc    = in_valid && (mq.size() < QD);
    e_go   = '0;
    e_done = 0;
    for (int i = 0; i < NE; i++) begin
      if (pend0[i]) begin
        e_done = 1; e_dtag = m_tag[i]; e_deng = EW'(i); m_pend[i] = 0;
        break;
      end
    end
    if (mq.size() > 0) begin
      h = mq[0];
      e = int'(h.eng);
      if (e >= NE) begin
        void'(mq.pop_front());
        e_bad = 1;
      end else if (!busy0[e] && !pend0[e] && (!h.barrier || (busy0 == 0 && pend0 == 0))) begin
        void'(mq.pop_front());
        e_go[e] = 1'b1;
        m_busy[e] = 1;
        m_tag[e] = h.tag;
        m_ax[e*AW +: AW] = h.addr_x;
        m_ay[e*AW +: AW] = h.addr_y;
        m_az[e*AW +: AW] = h.addr_z;
      end
    end
    for (int i = 0; i < NE; i++) begin
      if (in_done[i]) begin
        if (busy0[i]) begin m_busy[i] = 0; m_pend[i] = 1; end
        else e_spur = 1;
      end
    end
    if (acc) begin
      nj.eng = in_eng; nj.barrier = in_bar; nj.tag = in_tag;
      nj.addr_x = in_ax; nj.addr_y = in_ay; nj.addr_z = in_az;
      mq.push_back(nj);
    end
    e_idle = (mq.size() == 0) && (m_busy == 0) && (m_pend == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic push_one(input logic [EW-1:0] e, input logic b,
                          input logic [TW-1:0] t, input logic [AW-1:0] x);
    in_valid = 1'b1; in_eng = e; in_bar = b; in_tag = t;
    in_ax = x; in_ay = AW'($urandom); in_az = AW'($urandom);
    tick();
    in_valid = 1'b0; in_bar = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    n_cmp++; if (go !== '0) begin n_bad++; $display("FAIL reset_go: got %b want 000", go); end
    n_cmp++; if (busy !== '0) begin n_bad++; $display("FAIL reset_busy: got %b want 000", busy); end
    n_cmp++; if ((oax | oay | oaz) !== '0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", oax | oay | oaz); end
    n_cmp++; if (jd !== 1'b0 || jtag !== '0 || jeng !== '0) begin n_bad++; $display("FAIL reset_done: got %b/%h/%0d want 0/0/0", jd, jtag, jeng); end
    n_cmp++; if (level !== '0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle: got %b want 1", idle); end
    n_cmp++; if (ebad !== 1'b0 || espur !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b%b want 00", ebad, espur); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready); end
  endtask

  task automatic test_single();
    push_one(EW'(ENG_CNN), 1'b0, 8'h11, 19'h100);
    n_cmp++; if (go !== 3'b000) begin n_bad++; $display("FAIL single_go_early: got %b want 000", go); end
    n_cmp++; if (level !== 4'd1) begin n_bad++; $display("FAIL single_level: got %0d want 1", level); end
    tick();
    n_cmp++; if (go !== 3'b100) begin n_bad++; $display("FAIL single_go: got %b want 100", go); end
    n_cmp++; if (oax[2*AW +: AW] !== 19'h100) begin n_bad++; $display("FAIL single_addr_x: got %h want 100", oax[2*AW +: AW]); end
    n_cmp++; if (busy !== 3'b100 || idle !== 1'b0) begin n_bad++; $display("FAIL single_busy: got %b/%b want 100/0", busy, idle); end
    tick();
    n_cmp++; if (go !== 3'b000) begin n_bad++; $display("FAIL single_go_pulse: got %b want 000", go); end
    in_done = 3'b100; tick(); in_done = '0;
    n_cmp++; if (jd !== 1'b0 || busy !== 3'b000) begin n_bad++; $display("FAIL single_done_lat: got jd=%b busy=%b want 0/000", jd, busy); end
    tick();
    n_cmp++; if (jd !== 1'b1 || jtag !== 8'h11 || jeng !== 2'd2) begin n_bad++; $display("FAIL single_job_done: got %b/%h/%0d want 1/11/2", jd, jtag, jeng); end
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL single_idle: got %b want 1", idle); end
    tick();
    n_cmp++; if (jd !== 1'b0) begin n_bad++; $display("FAIL single_done_pulse: got %b want 0", jd); end
  endtask

  task automatic test_fill();
    in_valid = 1'b1; in_eng = EW'(ENG_FCC); in_bar = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_tag = 8'h20 + 8'(i); in_ax = AW'($urandom);
      tick();
    end
    n_cmp++; if (level !== 4'd8 || ready !== 1'b0) begin n_bad++; $display("FAIL fill_full: got level=%0d ready=%b want 8/0", level, ready); end
    in_tag = 8'hFF; tick(); in_valid = 1'b0;
    n_cmp++; if (level !== 4'd8) begin n_bad++; $display("FAIL fill_reject: got %0d want 8", level); end
    for (int k = 0; k < 9; k++) begin
      in_done = 3'b001; tick(); in_done = '0;
      tick();
      n_cmp++; if (jd !== 1'b1 || jtag !== 8'h20 + 8'(k)) begin n_bad++; $display("FAIL fill_tag%0d: got %b/%h want 1/%h", k, jd, jtag, 8'h20 + 8'(k)); end
      tick();
      n_cmp++; if (go !== ((k < 8) ? 3'b001 : 3'b000) || level !== ((k < 8) ? LW'(7 - k) : LW'(0))) begin
        n_bad++; $display("FAIL fill_release%0d: got go=%b level=%0d", k, go, level);
      end
    end
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL fill_idle: got %b want 1", idle); end
  endtask

  task automatic test_multi();
    for (int e = 0; e < NE; e++) push_one(EW'(e), 1'b0, 8'h30 + 8'(e), AW'($urandom));
    for (int w = 0; w < 10 && busy !== 3'b111; w++) tick();
    n_cmp++; if (busy !== 3'b111) begin n_bad++; $display("FAIL multi_busy: got %b want 111", busy); end
    in_done = 3'b111; tick(); in_done = '0;
    n_cmp++; if (jd !== 1'b0) begin n_bad++; $display("FAIL multi_lat: got %b want 0", jd); end
    for (int e = 0; e < NE; e++) begin
      tick();
      n_cmp++; if (jd !== 1'b1 || jeng !== EW'(e) || jtag !== 8'h30 + 8'(e)) begin
        n_bad++; $display("FAIL multi_order%0d: got %b/%0d/%h want 1/%0d/%h", e, jd, jeng, jtag, e, 8'h30 + 8'(e));
      end
    end
    tick();
    n_cmp++; if (jd !== 1'b0 || idle !== 1'b1) begin n_bad++; $display("FAIL multi_end: got jd=%b idle=%b want 0/1", jd, idle); end
  endtask

  task automatic test_barrier();
    push_one(EW'(ENG_POOL), 1'b0, 8'h41, AW'($urandom));
    tick();
    push_one(EW'(ENG_FCC), 1'b1, 8'h42, AW'($urandom));
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (go !== 3'b000) begin n_bad++; $display("FAIL barrier_hold%0d: got %b want 000", i, go); end
    end
    in_done = 3'b010; tick(); in_done = '0;
    tick();
    n_cmp++; if (jd !== 1'b1 || jeng !== 2'd1 || go !== 3'b000) begin n_bad++; $display("FAIL barrier_done: got %b/%0d go=%b want 1/1/000", jd, jeng, go); end
    tick();
    n_cmp++; if (go !== 3'b001) begin n_bad++; $display("FAIL barrier_go: got %b want 001", go); end
    in_done = 3'b001; tick(); in_done = '0;
    tick();
    n_cmp++; if (jd !== 1'b1 || jtag !== 8'h42) begin n_bad++; $display("FAIL barrier_tag: got %b/%h want 1/42", jd, jtag); end
  endtask

  task automatic test_bad_eng();
    push_one(2'd3, 1'b0, 8'h55, AW'($urandom));
    tick();
    n_cmp++; if (ebad !== 1'b1 || go !== 3'b000 || level !== 4'd0) begin n_bad++; $display("FAIL bad_drop: got err=%b go=%b level=%0d want 1/000/0", ebad, go, level); end
    tick();
    n_cmp++; if (jd !== 1'b0 || ebad !== 1'b1 || idle !== 1'b1) begin n_bad++; $display("FAIL bad_sticky: got jd=%b err=%b idle=%b want 0/1/1", jd, ebad, idle); end
    push_one(EW'(ENG_POOL), 1'b0, 8'h56, AW'($urandom));
    tick();
    n_cmp++; if (go !== 3'b010) begin n_bad++; $display("FAIL bad_next_go: got %b want 010", go); end
    in_done = 3'b010; tick(); in_done = '0;
    tick();
    n_cmp++; if (jd !== 1'b1 || jtag !== 8'h56) begin n_bad++; $display("FAIL bad_next_done: got %b/%h want 1/56", jd, jtag); end
  endtask

  task automatic test_spurious();
    tick();
    in_done = 3'b010; tick(); in_done = '0;
    n_cmp++; if (espur !== 1'b1) begin n_bad++; $display("FAIL spur_flag: got %b want 1", espur); end
    tick();
    n_cmp++; if (jd !== 1'b0 || espur !== 1'b1) begin n_bad++; $display("FAIL spur_no_done: got jd=%b err=%b want 0/1", jd, espur); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_eng   = ($urandom_range(0, 15) == 0) ? 2'd3 : EW'($urandom_range(0, NE - 1));
      in_bar   = ($urandom_range(0, 7) == 0);
      in_tag   = TW'($urandom);
      in_ax = AW'($urandom); in_ay = AW'($urandom); in_az = AW'($urandom);
      for (int i = 0; i < NE; i++)
        in_done[i] = m_busy[i] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 63) == 0);
      tick();
      n_cmp++; if (go !== e_go || busy !== m_busy) begin n_bad++; $display("FAIL rnd_go_busy c%0d: got %b/%b want %b/%b", c, go, busy, e_go, m_busy); end
      n_cmp++; if (oax !== m_ax || oay !== m_ay || oaz !== m_az) begin n_bad++; $display("FAIL rnd_addr c%0d: got %h want %h", c, oax, m_ax); end
      n_cmp++; if (jd !== e_done) begin n_bad++; $display("FAIL rnd_done c%0d: got %b want %b", c, jd, e_done); end
      if (e_done) begin
        n_cmp++; if (jtag !== e_dtag || jeng !== e_deng) begin n_bad++; $display("FAIL rnd_done_id c%0d: got %h/%0d want %h/%0d", c, jtag, jeng, e_dtag, e_deng); end
      end
      n_cmp++; if (level !== LW'(mq.size()) || ready !== (mq.size() < QD)) begin n_bad++; $display("FAIL rnd_level c%0d: got %0d/%b want %0d", c, level, ready, mq.size()); end
      n_cmp++; if (idle !== e_idle || ebad !== e_bad || espur !== e_spur) begin n_bad++; $display("FAIL rnd_flags c%0d: got %b%b%b want %b%b%b", c, idle, ebad, espur, e_idle, e_bad, e_spur); end
    end
    in_valid = 1'b0; in_bar = 1'b0; in_done = '0;
  endtask

  task automatic test_midreset();
    in_valid = 1'b1; in_eng = EW'(ENG_FCC); in_bar = 1'b0;
    for (int i = 0; i < 4; i++) begin in_tag = 8'h60 + 8'(i); tick(); end
    in_valid = 1'b0;
    n_cmp++; if (level !== LW'(mq.size())) begin n_bad++; $display("FAIL midrst_pre_level: got %0d want %0d", level, mq.size()); end
    in_done = m_busy; tick(); in_done = '0;
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if (level !== '0 || busy !== '0 || idle !== 1'b1) begin n_bad++; $display("FAIL midrst_state: got level=%0d busy=%b idle=%b want 0/000/1", level, busy, idle); end
    n_cmp++; if (jd !== 1'b0 || ebad !== 1'b0 || espur !== 1'b0 || ready !== 1'b1) begin n_bad++; $display("FAIL midrst_outs: got jd=%b err=%b%b ready=%b want 0/00/1", jd, ebad, espur, ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (jd !== 1'b0 || go !== '0) begin n_bad++; $display("FAIL midrst_quiet%0d: got jd=%b go=%b want 0/000", i, jd, go); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_multi();
    test_barrier();
    test_bad_eng();
    test_spurious();
    test_random();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
